// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg: state encoding and counter type shared by pixel_sequencer and its timer.
package pixel_seq_pkg;
  localparam int PKG_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, GAP} pixel_seq_state_t;
  typedef logic [PKG_CNT_W-1:0] pixel_seq_cnt_t;
endpackage

// File: rtl/pixel_seq_timer.sv
// pixel_seq_timer: loadable down-counter that holds at zero and flags it.
module pixel_seq_timer
  import pixel_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: per-frame erase/expose/convert/read strobe sequencer with start/busy/done.
// Define PIXEL_SEQ_GAP_EN to insert a one-cycle all-low GAP between consecutive phases.
module pixel_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int N_READ         = 4,
  parameter int CNT_W          = 8,
  parameter int ERASE_CYCLES   = 5,
  parameter int CONVERT_CYCLES = 255,
  parameter int READ_CYCLES    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [CNT_W-1:0]  exp_time,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_READ-1:0] read,
  output logic              busy,
  output logic              done
);
  localparam int RW = N_READ > 1 ? $clog2(N_READ) : 1;
  localparam logic [CNT_W-1:0] E_LD = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LD = CNT_W'(CONVERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LD = CNT_W'(READ_CYCLES - 1);

  pixel_seq_state_t  state_q, state_d, tgt;
  logic [RW-1:0]     ridx_q, ridx_d;
  logic [CNT_W-1:0]  exp_q, exp_d, load_val;
  logic              load, zero, go, last, done_d;
  logic              erase_q, expose_q, convert_q, busy_q, done_q;
  logic [N_READ-1:0] read_q, read_d;
`ifdef PIXEL_SEQ_GAP_EN
  pixel_seq_state_t  nxt_q, nxt_d;
`endif

  // Counter load value on entry to a phase; an exposure of 0 still lasts one cycle.
  function automatic logic [CNT_W-1:0] ld(input pixel_seq_state_t s, input logic [CNT_W-1:0] x);
    return s == ERASE ? E_LD : s == EXPOSE ? (x == '0 ? x : x - 1'b1) : s == CONVERT ? C_LD : R_LD;
  endfunction

  pixel_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign last = ridx_q == RW'(N_READ - 1);

  always_comb begin
    state_d  = state_q;
    ridx_d   = ridx_q;
    exp_d    = exp_q;
    done_d   = 1'b0;
    go       = 1'b0;
    tgt      = IDLE;
    load     = 1'b0;
    load_val = '0;
`ifdef PIXEL_SEQ_GAP_EN
    nxt_d    = nxt_q;
`endif
    if (abort) begin
      state_d = IDLE;
      ridx_d  = '0;
      load    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          go  = start;
          tgt = ERASE;
          if (start) exp_d = exp_time;
        end
        ERASE:   begin go = zero; tgt = EXPOSE;  end
        EXPOSE:  begin go = zero; tgt = CONVERT; end
        CONVERT: begin go = zero; tgt = READ;    end
        READ: if (zero) begin
          go     = !last || cont;
          tgt    = last ? ERASE : READ;
          ridx_d = last ? '0 : ridx_q + 1'b1;
          done_d = last;
          if (last && cont) exp_d = exp_time;
          if (last && !cont) state_d = IDLE;
        end
`ifdef PIXEL_SEQ_GAP_EN
        GAP: begin go = 1'b1; tgt = nxt_q; end
`endif
        default: state_d = IDLE;
      endcase
      if (go) begin
`ifdef PIXEL_SEQ_GAP_EN
        if (state_q == IDLE || state_q == GAP) begin
          state_d  = tgt;
          load     = 1'b1;
          load_val = ld(tgt, exp_d);
        end else begin
          state_d = GAP;
          nxt_d   = tgt;
        end
`else
        state_d  = tgt;
        load     = 1'b1;
        load_val = ld(tgt, exp_d);
`endif
      end
    end
    read_d = state_d == READ ? N_READ'(1) << ridx_d : '0;
  end

  // Strobes are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      ridx_q    <= '0;
      exp_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      read_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ridx_q    <= ridx_d;
      exp_q     <= exp_d;
      erase_q   <= state_d == ERASE;
      expose_q  <= state_d == EXPOSE;
      convert_q <= state_d == CONVERT;
      read_q    <= read_d;
      busy_q    <= state_d != IDLE;
      done_q    <= done_d;
    end

`ifdef PIXEL_SEQ_GAP_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) nxt_q <= IDLE;
    else nxt_q <= nxt_d;
`endif

  assign erase   = erase_q;
  assign expose  = expose_q;
  assign convert = convert_q;
  assign read    = read_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: builds per-cycle expected strobe waveforms from phase durations and compares.
module tb_pixel_sequencer;
  localparam int N = 2, E = 2, C = 3, R = 2, W = 8;
`ifdef PIXEL_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic [W-1:0] exp_time = '0;
  logic erase, expose, convert, busy, done;
  logic [N-1:0] read;
  int checks = 0, failures = 0;
  logic [6:0] q[$];
  int fs[$];
  bit pend;
  int xs[4];

  always #5 clk = ~clk;

  pixel_sequencer #(
    .N_READ(N), .CNT_W(W), .ERASE_CYCLES(E), .CONVERT_CYCLES(C), .READ_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .abort(abort), .exp_time(exp_time),
    .erase(erase), .expose(expose), .convert(convert), .read(read), .busy(busy), .done(done)
  );

  // Observed vector layout: {busy, done, erase, expose, convert, read[1:0]}.
  function automatic logic [6:0] obs();
    return {busy, done, erase, expose, convert, read};
  endfunction

  function automatic void put(logic [6:0] v);
    q.push_back(v | (pend ? 7'b0100000 : 7'b0));
    pend = 1'b0;
  endfunction

  function automatic void phase(logic [6:0] v, int n);
    for (int i = 0; i < n; i++) put(v);
  endfunction

  function automatic void gapc();
    if (GAP_ON) put(7'b1000000);
  endfunction

  // Expected waveform from cycle 1 (first erase) for nfr frames with exposures xs[0..nfr-1].
  function automatic void build(int nfr);
    q.delete();
    fs.delete();
    pend = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      fs.push_back(q.size());
      phase(7'b1010000, E); gapc();
      phase(7'b1001000, xs[f] == 0 ? 1 : xs[f]); gapc();
      phase(7'b1000100, C); gapc();
      for (int r = 0; r < N; r++) begin
        phase(7'b1000000 | 7'(1 << r), R);
        if (r < N - 1) gapc();
      end
      pend = 1'b1;
      if (f < nfr - 1) gapc();
    end
    put(7'b0);
    put(7'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    exp_time = W'(xs[0]);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rand_xs();
    for (int i = 0; i < 4; i++) xs[i] = $urandom_range(0, 6);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    step();
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL reset got=%b exp=%b", obs(), 7'b0); end
    reset = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs(), 7'b0); end
  endtask

  task automatic test_single_frame(input int x0);
    rand_xs();
    xs[0] = x0;
    build(1);
    kick();
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin exp_time = W'(xs[1]); cont = 1'b0; end
      start = (i < q.size() - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      checks++;
      if (obs() !== q[i]) begin
        failures++;
        $display("FAIL single x=%0d cyc=%0d got=%b exp=%b", x0, i + 1, obs(), q[i]);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_continuous();
    int fi;
    rand_xs();
    build(3);
    fi = 0;
    cont = 1'b1;
    kick();
    for (int i = 0; i < q.size(); i++) begin
      if (fi < fs.size() && i == fs[fi]) begin
        exp_time = W'(xs[fi + 1]);
        cont = fi < 2;
        fi++;
      end
      checks++;
      if (obs() !== q[i]) begin
        failures++;
        $display("FAIL cont cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]);
      end
      step();
    end
    cont = 1'b0;
  endtask

  task automatic test_abort();
    int k;
    rand_xs();
    xs[0] = 4;
    build(1);
    k = $urandom_range(2, q.size() - 4);
    kick();
    for (int i = 0; i < k; i++) begin
      checks++;
      if (obs() !== q[i]) begin failures++; $display("FAIL abort_pre cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]); end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL abort_idle cyc=%0d got=%b exp=%b", k + 1, obs(), 7'b0); end
    step();
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=%b", obs(), 7'b0); end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL abort_beats_start got=%b exp=%b", obs(), 7'b0); end
    kick();
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (obs() !== q[i]) begin failures++; $display("FAIL abort_after cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]); end
      step();
    end
  endtask

  task automatic test_async_reset();
    int k;
    rand_xs();
    build(1);
    k = $urandom_range(3, q.size() - 4);
    kick();
    for (int i = 0; i < k; i++) begin
      checks++;
      if (obs() !== q[i]) begin failures++; $display("FAIL rst_pre cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]); end
      step();
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL rst_async got=%b exp=%b", obs(), 7'b0); end
    start = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL rst_hold got=%b exp=%b", obs(), 7'b0); end
    kick();
    for (int i = 0; i < q.size(); i++) begin
      start = (i > 0 && i < 4);
      checks++;
      if (obs() !== q[i]) begin failures++; $display("FAIL rst_after cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]); end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    rand_xs();
    build(1);
    q[q.size() - 1] = 7'b1010000;
    kick();
    for (int i = 0; i < q.size(); i++) begin
      start = i == q.size() - 2;
      if (i == q.size() - 2) exp_time = W'(xs[1]);
      checks++;
      if (obs() !== q[i]) begin failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i + 1, obs(), q[i]); end
      step();
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs() !== 7'b0) begin failures++; $display("FAIL b2b_abort got=%b exp=%b", obs(), 7'b0); end
  endtask

  initial begin
    test_reset();
    test_single_frame(4);
    test_single_frame(0);
    test_single_frame($urandom_range(1, 6));
    test_continuous();
    test_continuous();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_sequencer.md
# pixel_sequencer

Parametrised frame-timing sequencer for the pixel array: drives the global erase, expose and convert strobes, then a configurable number of one-hot read strobes, once per frame. It is the successor to the fixed 4-read pixel state machine. It adds a runtime exposure time, start/busy/done handshake, continuous mode, abort, and optional non-overlap gaps. It sits between the top-level controller and the pixel array/ADC column logic.

## Interface

**Parameters**
- `N_READ`, 4: number of read phases and width of `read` (≥1).
- `CNT_W`, 8: width of the phase down-counter and `exp_time`.
- `ERASE_CYCLES`, 5: erase phase length in cycles (1..2^CNT_W).
- `CONVERT_CYCLES`, 255: convert phase length in cycles (1..2^CNT_W).
- `READ_CYCLES`, 5: length of each read phase in cycles (1..2^CNT_W).

**Ports**
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: frame request; sampled only in IDLE.
- `cont`, input, 1: continuous mode; sampled at the end of the last read.
- `abort`, input, 1: synchronous abort; highest priority after reset.
- `exp_time`, input, CNT_W: expose length in cycles; latched on accepted `start` and on each continuous restart. 0 is treated as 1.
- `erase`, `expose`, `convert`, output, 1: phase strobes.
- `read`, output, N_READ: one-hot read strobe; bit i is high during read phase i.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of each completed frame.

## Operation

- States: IDLE, ERASE, EXPOSE, CONVERT, READ, GAP. Read index `ridx` runs 0..N_READ-1.
- Phase order: ERASE → EXPOSE → CONVERT → READ(0) … READ(N_READ-1). A GAP state sits between every pair of phases when enabled (see Configuration).
- Each phase loads the down-counter with duration-1. The phase exits on the cycle the counter reads 0, so each strobe is high for exactly its duration.
- All outputs are registered and updated on the same edge as the state, so they are glitch-free.
- Exactly one strobe is high at any time; in IDLE and GAP all strobes are low.
- IDLE:
  - `start`=1 → ERASE.
  - `start` while busy is ignored; no queuing.
- End of the last read:
  - `done` pulses for one cycle.
  - `cont`=1 → restart at ERASE (through GAP if enabled), re-latching `exp_time`; `busy` stays high.
  - `cont`=0 → IDLE.
- `abort`=1 in any state → IDLE on the next edge. All strobes drop; no `done`; `ridx` and the counter are cleared. `abort` beats `start` in the same cycle.
- Reset value of every output is 0; state resets to IDLE, `ridx` and the counter to 0.
- Reset asserted mid-frame forces everything low asynchronously. The block restarts only on a new `start`.

## Timing

- `start` sampled at edge k → `erase` and `busy` high from edge k+1.
- With gaps, frame length (first erase cycle to last read cycle) = E+X+C+N·R+(N+2). Without gaps it is E+X+C+N·R.
- `done` is high during the cycle immediately after the last read cycle.
  - In that cycle `busy`=0 if the block stops.
  - In continuous mode, that cycle is the GAP cycle, or the first ERASE cycle when gaps are disabled.
- `done` and `start` never interact: `start` is ignored in the `done` cycle unless the state is already IDLE.

## Configuration

- `PIXEL_SEQ_GAP_EN` defined: one GAP cycle (all strobes low, `busy` high) between consecutive phases, including READ(i)→READ(i+1) and the continuous READ→ERASE wrap. This gives break-before-make for the array drivers.
- Not defined: phases are back-to-back and the GAP state is not generated.

## Structure

- `pixel_seq_pkg` holds:
  - the state enum `pixel_seq_state_t` (3 bits);
  - typedef `pixel_seq_cnt_t` (logic [CNT_W-1:0], via a package parameter defaulting to 8).
- Sub-module `pixel_seq_timer`: loadable CNT_W-bit down-counter with `load`, `load_val` and a `zero` flag. The main FSM instantiates it once.

## Test plan

Bench parameters: N_READ=2, E=2, C=3, R=2, gaps enabled, `exp_time`=4. `start` is pulsed at edge 0 unless stated otherwise.

- **Single frame:** erase high cycles 1–2, expose 4–7, convert 9–11, read=01 13–14, read=10 16–17, gaps at 3/8/12/15. `done` and `busy`=0 at cycle 18.
- **`exp_time`=0:** expose high for exactly 1 cycle. Changing `exp_time` mid-frame does not alter the current expose.
- **Continuous:** `cont`=1 → `done` pulses at 18, erase restarts at 19, `busy` never drops; second frame identical. Drop `cont` → stops after the second frame.
- **Abort during expose** (cycle 5): all strobes and `busy` are 0 at cycle 6, no `done`. A new `start` gives a full normal frame.
- **Async reset at cycle 10** (mid-convert): all outputs 0 immediately; `start` while busy and after release behaves as in the single-frame case.
- **Gap disabled build:** same stimulus gives erase 1–2, expose 3–6, convert 7–9, reads 10–11 and 12–13, `done` at 14.
